// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words,
// compares them against expected values and reports pass/fail/timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | waiting for start or the armed post-reset launch
// S_REQ_ID | read request on word 0, held until accepted
// S_LAT_ID | counting slave latency before capturing word 0
// S_REQ_TS | read request on word 1, held until accepted
// S_LAT_TS | counting slave latency before capturing word 1
// S_DONE   | result valid; start reruns the check
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1486332737,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_ID = 3'd1;
  localparam logic [2:0] S_LAT_ID = 3'd2;
  localparam logic [2:0] S_REQ_TS = 3'd3;
  localparam logic [2:0] S_LAT_TS = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [1:0]  LAT_LOAD  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [1:0]  lat_cnt;
  logic [15:0] wait_cnt;
  logic        auto_arm;
  logic        in_req;
  logic        accepted;
  logic        stall_out;
  logic        launch;
  logic        id_ok;
  logic        ts_ok_now;

  // Read is decoded from state so an async reset drops it immediately.
  assign in_req      = (state == S_REQ_ID) || (state == S_REQ_TS);
  assign avm_read    = in_req;
  assign avm_address = (state == S_REQ_TS) || (state == S_LAT_TS);
  assign accepted    = in_req && !avm_waitrequest;
  assign stall_out   = in_req && avm_waitrequest && (wait_cnt == WAIT_LAST);
  assign launch      = ((state == S_IDLE) && (start || auto_arm)) ||
                       ((state == S_DONE) && start);
  assign id_ok       = (id_value == EXPECTED_ID);
  assign ts_ok_now   = (avm_readdata == EXPECTED_TS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      lat_cnt  <= 2'd0;
      wait_cnt <= 16'd0;
      auto_arm <= AUTO_START;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      auto_arm <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state    <= S_REQ_ID;
            wait_cnt <= 16'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
          end
        end
        S_REQ_ID: begin
          if (accepted) begin
            wait_cnt <= 16'd0;
            if (READ_LATENCY == 0) begin
              id_value <= avm_readdata;
              state    <= S_REQ_TS;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= S_LAT_ID;
            end
          end else if (stall_out) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (avm_waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_LAT_ID: begin
          if (lat_cnt == 2'd0) begin
            id_value <= avm_readdata;
            wait_cnt <= 16'd0;
            state    <= S_REQ_TS;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_REQ_TS: begin
          if (accepted) begin
            if (READ_LATENCY == 0) begin
              ts_value <= avm_readdata;
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= id_ok && ts_ok_now;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= S_LAT_TS;
            end
          end else if (stall_out) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (avm_waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_LAT_TS: begin
          if (lat_cnt == 2'd0) begin
            ts_value <= avm_readdata;
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= id_ok && ts_ok_now;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the sysid checker: zero-latency, latency-2 with stalls,
// and short-timeout instances share one clock and reset.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_TS  = 32'd1486332737;
  localparam logic [31:0] BAD_TS  = 32'h5897_1340;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // u0: zero latency, default timeout
  logic        start0, addr0, read0, wr0, busy0, done0, pass0, to0, stall0;
  logic [31:0] rd0, id0, ts0, ts_word0;
  // u1: latency 2, stalled on word 1
  logic        start1, addr1, read1, wr1, busy1, done1, pass1, to1;
  logic [31:0] rd1, id1, ts1, p1, p2;
  logic [2:0]  stall_cnt1;
  int          rcnt1;
  // u2: timeout 8, waitrequest stuck high
  logic        start2, addr2, read2, wr2, busy2, done2, pass2, to2;
  logic [31:0] rd2, id2, ts2;
  int          rcnt2;

  assign rd0 = addr0 ? ts_word0 : 32'd0;
  assign wr0 = stall0 && addr0;

  assign rd1 = p2;
  assign wr1 = (read1 && addr1 && stall_cnt1 == 3'd0) ||
               (stall_cnt1 >= 3'd1 && stall_cnt1 < 3'd5);

  assign rd2 = 32'h1234_5678;
  assign wr2 = 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p1 <= GARBAGE;
      p2 <= GARBAGE;
      stall_cnt1 <= 3'd0;
      rcnt1 <= 0;
      rcnt2 <= 0;
    end else begin
      p1 <= (read1 && !wr1) ? (addr1 ? EXP_TS : 32'd0) : GARBAGE;
      p2 <= p1;
      if (stall_cnt1 == 3'd0) begin
        if (read1 && addr1) stall_cnt1 <= 3'd1;
      end else if (stall_cnt1 < 3'd5) begin
        stall_cnt1 <= stall_cnt1 + 3'd1;
      end
      if (read1 && addr1) rcnt1 <= rcnt1 + 1;
      if (read2) rcnt2 <= rcnt2 + 1;
    end
  end

  niosii_system_sysid_checker u0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wr0), .avm_readdata(rd0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(to0), .id_value(id0), .ts_value(ts0)
  );

  niosii_system_sysid_checker #(.READ_LATENCY(2)) u1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wr1), .avm_readdata(rd1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(to1), .id_value(id1), .ts_value(ts1)
  );

  niosii_system_sysid_checker #(.TIMEOUT_CYCLES(8)) u2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(addr2), .avm_read(read2), .avm_waitrequest(wr2), .avm_readdata(rd2),
    .busy(busy2), .done(done2), .pass(pass2), .timeout(to2), .id_value(id2), .ts_value(ts2)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    stall0 = 1'b0;
    ts_word0 = EXP_TS;
    repeat (3) @(negedge clock);
    check1("rst_read", read0, 1'b0);
    check1("rst_busy", busy0, 1'b0);
    check1("rst_done", done0, 1'b0);
    check1("rst_pass", pass0, 1'b0);
    check32("rst_ts", ts0, 32'd0);
    reset = 1'b0;

    // Test 1: auto launch, reads on cycles 1 and 2, done on cycle 3
    @(negedge clock);
    check1("t1_c1_read", read0, 1'b1);
    check1("t1_c1_addr", addr0, 1'b0);
    check1("t1_c1_busy", busy0, 1'b1);
    @(negedge clock);
    check1("t1_c2_read", read0, 1'b1);
    check1("t1_c2_addr", addr0, 1'b1);
    check1("t1_c2_busy", busy0, 1'b1);
    @(negedge clock);
    check1("t1_c3_done", done0, 1'b1);
    check1("t1_c3_pass", pass0, 1'b1);
    check1("t1_c3_busy", busy0, 1'b0);
    check1("t1_c3_read", read0, 1'b0);
    check32("t1_ts", ts0, EXP_TS);
    check32("t1_id", id0, 32'd0);

    // Test 3: latency 2 with a 5-cycle stall on word 1
    for (int i = 0; i < 30 && !done1; i++) begin
      @(negedge clock);
      if (stall_cnt1 >= 3'd1 && stall_cnt1 < 3'd5) begin
        check1("t3_stall_read", read1, 1'b1);
        check1("t3_stall_addr", addr1, 1'b1);
      end
    end
    check1("t3_done", done1, 1'b1);
    check1("t3_pass", pass1, 1'b1);
    check32("t3_ts", ts1, EXP_TS);
    check32("t3_id", id1, 32'd0);
    check32("t3_ts_read_cycles", 32'(rcnt1), 32'd6);

    // Test 4: stuck waitrequest on word 0, timeout after 8 stalled cycles
    check1("t4_done", done2, 1'b1);
    check1("t4_timeout", to2, 1'b1);
    check1("t4_pass", pass2, 1'b0);
    check1("t4_read", read2, 1'b0);
    check1("t4_busy", busy2, 1'b0);
    check32("t4_id", id2, 32'd0);
    check32("t4_read_cycles", 32'(rcnt2), 32'd8);

    // Test 2: restart from DONE with a wrong timestamp
    ts_word0 = BAD_TS;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    check1("t2_busy", busy0, 1'b1);
    check1("t2_done_clr", done0, 1'b0);
    check1("t2_pass_clr", pass0, 1'b0);
    check32("t2_ts_clr", ts0, 32'd0);
    for (int i = 0; i < 20 && !done0; i++) @(negedge clock);
    check1("t2_done", done0, 1'b1);
    check1("t2_pass", pass0, 1'b0);
    check1("t2_timeout", to0, 1'b0);
    check32("t2_ts", ts0, BAD_TS);

    // Test 5: start held into the busy cycle is ignored, not queued
    ts_word0 = EXP_TS;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b1;
    check1("t5_busy", busy0, 1'b1);
    check32("t5_ts_clr", ts0, 32'd0);
    @(negedge clock); start0 = 1'b0;
    @(negedge clock);
    check1("t5_done", done0, 1'b1);
    check1("t5_pass", pass0, 1'b1);
    repeat (2) @(negedge clock);
    check1("t5_no_rerun_busy", busy0, 1'b0);
    check1("t5_no_rerun_done", done0, 1'b1);

    // Test 6: reset asserted while stalled in REQ_TS
    stall0 = 1'b1;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    repeat (2) @(negedge clock);
    check1("t6_stall_read", read0, 1'b1);
    check1("t6_stall_addr", addr0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check1("t6_rst_read", read0, 1'b0);
    check1("t6_rst_busy", busy0, 1'b0);
    check1("t6_rst_done", done0, 1'b0);
    check1("t6_rst_timeout", to0, 1'b0);
    check32("t6_rst_id", id0, 32'd0);
    @(negedge clock);
    stall0 = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check1("t6_relaunch_read", read0, 1'b1);
    check1("t6_relaunch_addr", addr0, 1'b0);
    for (int i = 0; i < 20 && !done0; i++) @(negedge clock);
    check1("t6_done", done0, 1'b1);
    check1("t6_pass", pass0, 1'b1);
    check32("t6_ts", ts0, EXP_TS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
